// File: rtl/alu_bitop_seq.sv
// alu_bitop_seq: slice-serial BIT/RES/SET bit unit; define ALU_BITOP_TGL_EN to make op 11 a toggle instead of pass-through
module alu_bitop_seq #(
    parameter int DATA_W  = 8,
    parameter int SLICE_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  op,
    input  logic [DATA_W-1:0]           operand,
    input  logic [$clog2(DATA_W)-1:0]   bitsel,
    input  logic                        carry_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           result,
    output logic                        zero,
    output logic                        carry,
    output logic                        half
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int N     = DATA_W / SLICE_W;
    localparam int CW    = N > 1 ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  opnd_q;
    logic [IDX_W-1:0]   sel_q;
    logic [CW-1:0]      k;
    logic [DATA_W-1:0]  mask;
    logic [SLICE_W-1:0] slice_op;
    logic [SLICE_W-1:0] mask_k;
    logic [SLICE_W-1:0] r_k;
    logic               z_k;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign mask      = {{(DATA_W-1){1'b0}}, 1'b1} << sel_q;
    assign slice_op  = opnd_q[k*SLICE_W +: SLICE_W];
    assign mask_k    = mask[k*SLICE_W +: SLICE_W];
`ifdef ALU_BITOP_TGL_EN
    assign r_k = op_q == 2'b01 ? slice_op & ~mask_k :
                 op_q == 2'b10 ? slice_op | mask_k :
                 op_q == 2'b11 ? slice_op ^ mask_k : slice_op;
`else
    assign r_k = op_q == 2'b01 ? slice_op & ~mask_k :
                 op_q == 2'b10 ? slice_op | mask_k : slice_op;
`endif
    assign z_k = op_q == 2'b00 ? (slice_op & mask_k) == '0 : r_k == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            opnd_q <= '0;
            sel_q  <= '0;
            k      <= '0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            half   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            state  <= RUN;
            op_q   <= op;
            opnd_q <= operand;
            sel_q  <= bitsel;
            k      <= '0;
            zero   <= 1'b1;
            carry  <= carry_in;
            half   <= op == 2'b00;
        end else if (state == RUN) begin
            result[k*SLICE_W +: SLICE_W] <= r_k;
            zero  <= zero & z_k;
            k     <= k + 1'b1;
            state <= k == CW'(N-1) ? DONE : RUN;
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule
